// File: rtl/ram_responder.sv
// Memory-side responder: accepts one RAM request at a time, waits WAIT_STATES cycles,
// accesses an internal synchronous word array, then returns data or a write echo.
module ram_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic              RAM_WREN,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic              RESP_VALID,
    input  logic              RESP_READY,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              RESP_ERR,
    output logic              BUSY
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] WS_V = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wren;
    logic [DATA_W-1:0]   r_data;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_dout;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic                w_mem_we;

    // Range check uses the full address so nothing aliases when DEPTH < 2^ADDR_W.
    assign w_in_range = ({1'b0, r_addr} < DEPTH_V);
    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_mem_we   = RESET_N && (r_state == S_ACCESS) && r_wren && w_in_range;

    assign DATA_OUT = r_dout;
    assign RESP_ERR = r_err;

    always_comb begin
        w_next     = r_state;
        REQ_READY  = 1'b0;
        RESP_VALID = 1'b0;
        BUSY       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                REQ_READY = 1'b1;
                BUSY      = 1'b0;
                if (REQ_VALID) begin
                    w_next = (WS_V != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                RESP_VALID = 1'b1;
                if (RESP_READY) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wren  <= 1'b0;
            r_data  <= '0;
            r_cnt   <= 4'd0;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        r_addr <= ADDR_IN;
                        r_wren <= RAM_WREN;
                        r_data <= DATA_IN;
                        r_cnt  <= WS_V;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_ACCESS: begin
                    if (!w_in_range) begin
                        r_dout <= '0;
                        r_err  <= 1'b1;
                    end else if (r_wren) begin
                        r_dout <= r_data;
                        r_err  <= 1'b0;
                    end else begin
                        r_dout <= r_mem[w_idx];
                        r_err  <= 1'b0;
                    end
                end
                S_RESP: begin
                    // DATA_OUT deliberately keeps its value after the handshake.
                    if (RESP_READY) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Storage is never reset; a reset at the ACCESS edge suppresses the commit.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_data;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder: four instances with different
// DEPTH/WAIT_STATES share one stimulus bus; each test watches its own instance.
module tb_ram_responder;

    logic       clk;
    logic       resetN;
    logic       reqValid;
    logic [9:0] reqAddr;
    logic       reqWren;
    logic [7:0] reqData;
    logic       respReady;

    logic       reqReady  [4];
    logic       respValid [4];
    logic [7:0] dataOut   [4];
    logic       respErr   [4];
    logic       busy      [4];

    int passCount;
    int checkCount;

    // Instance 0: WS=1 DEPTH=1024, 1: WS=1 DEPTH=512, 2: WS=4, 3: WS=0
    ram_responder #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .WAIT_STATES(1)) u_ws1 (
        .CLK(clk), .RESET_N(resetN), .REQ_VALID(reqValid), .REQ_READY(reqReady[0]),
        .ADDR_IN(reqAddr), .RAM_WREN(reqWren), .DATA_IN(reqData),
        .RESP_VALID(respValid[0]), .RESP_READY(respReady), .DATA_OUT(dataOut[0]),
        .RESP_ERR(respErr[0]), .BUSY(busy[0]));

    ram_responder #(.ADDR_W(10), .DATA_W(8), .DEPTH(512), .WAIT_STATES(1)) u_d512 (
        .CLK(clk), .RESET_N(resetN), .REQ_VALID(reqValid), .REQ_READY(reqReady[1]),
        .ADDR_IN(reqAddr), .RAM_WREN(reqWren), .DATA_IN(reqData),
        .RESP_VALID(respValid[1]), .RESP_READY(respReady), .DATA_OUT(dataOut[1]),
        .RESP_ERR(respErr[1]), .BUSY(busy[1]));

    ram_responder #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .WAIT_STATES(4)) u_ws4 (
        .CLK(clk), .RESET_N(resetN), .REQ_VALID(reqValid), .REQ_READY(reqReady[2]),
        .ADDR_IN(reqAddr), .RAM_WREN(reqWren), .DATA_IN(reqData),
        .RESP_VALID(respValid[2]), .RESP_READY(respReady), .DATA_OUT(dataOut[2]),
        .RESP_ERR(respErr[2]), .BUSY(busy[2]));

    ram_responder #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .RESET_N(resetN), .REQ_VALID(reqValid), .REQ_READY(reqReady[3]),
        .ADDR_IN(reqAddr), .RAM_WREN(reqWren), .DATA_IN(reqData),
        .RESP_VALID(respValid[3]), .RESP_READY(respReady), .DATA_OUT(dataOut[3]),
        .RESP_ERR(respErr[3]), .BUSY(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic applyReset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    // Runs one request on instance d. Latency counts edges with the accepting edge as 1.
    // Inputs are scrambled after acceptance to show the in-flight access is latched.
    task automatic doTxn(input int d, input logic wr, input logic [9:0] a, input logic [7:0] wd,
                         output logic [7:0] rd, output logic e, output int lat);
        int n;
        reqValid = 1'b1;
        reqWren  = wr;
        reqAddr  = a;
        reqData  = wd;
        n = 0;
        while (!reqReady[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        reqValid = 1'b0;
        reqWren  = ~wr;
        reqAddr  = ~a;
        reqData  = ~wd;
        lat = 1;
        while (!respValid[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = dataOut[d];
        e  = respErr[d];
        if (respReady) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        applyReset();
        @(posedge clk); #1;
        checkCount++;
        if (reqReady[0] !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", reqReady[0]);
        else passCount++;
        checkCount++;
        if (respValid[0] !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", respValid[0]);
        else passCount++;
        checkCount++;
        if (busy[0] !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy[0]);
        else passCount++;
        checkCount++;
        if (dataOut[0] !== 8'h00) $display("[TB] FAIL reset_data_out: got %h expected 00", dataOut[0]);
        else passCount++;
        checkCount++;
        if (respErr[2] !== 1'b0) $display("[TB] FAIL reset_resp_err: got %b expected 0", respErr[2]);
        else passCount++;
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        logic       e;
        int         lat;
        applyReset();
        doTxn(0, 1'b1, 10'h003, 8'hA5, rd, e, lat);
        checkCount++;
        if (lat !== 3) $display("[TB] FAIL wr_latency: got %0d expected 3", lat);
        else passCount++;
        checkCount++;
        if (rd !== 8'hA5) $display("[TB] FAIL wr_echo: got %h expected a5", rd);
        else passCount++;
        checkCount++;
        if (e !== 1'b0) $display("[TB] FAIL wr_err: got %b expected 0", e);
        else passCount++;
        doTxn(0, 1'b0, 10'h003, 8'h00, rd, e, lat);
        checkCount++;
        if (lat !== 3) $display("[TB] FAIL rd_latency: got %0d expected 3", lat);
        else passCount++;
        checkCount++;
        if (rd !== 8'hA5) $display("[TB] FAIL rd_data: got %h expected a5", rd);
        else passCount++;
        checkCount++;
        if (e !== 1'b0) $display("[TB] FAIL rd_err: got %b expected 0", e);
        else passCount++;
        checkCount++;
        if (busy[0] !== 1'b0 || reqReady[0] !== 1'b1)
            $display("[TB] FAIL rd_back_to_idle: got busy=%b ready=%b expected busy=0 ready=1", busy[0], reqReady[0]);
        else passCount++;
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd;
        logic       e;
        int         lat;
        applyReset();
        doTxn(1, 1'b1, 10'h000, 8'h42, rd, e, lat);
        doTxn(1, 1'b1, 10'h200, 8'h3C, rd, e, lat);
        checkCount++;
        if (e !== 1'b1) $display("[TB] FAIL oor_wr_err: got %b expected 1", e);
        else passCount++;
        checkCount++;
        if (rd !== 8'h00) $display("[TB] FAIL oor_wr_data: got %h expected 00", rd);
        else passCount++;
        checkCount++;
        if (respErr[1] !== 1'b0) $display("[TB] FAIL oor_err_cleared: got %b expected 0", respErr[1]);
        else passCount++;
        doTxn(1, 1'b0, 10'h200, 8'h00, rd, e, lat);
        checkCount++;
        if (e !== 1'b1 || rd !== 8'h00)
            $display("[TB] FAIL oor_rd: got err=%b data=%h expected err=1 data=00", e, rd);
        else passCount++;
        doTxn(1, 1'b0, 10'h3FF, 8'h00, rd, e, lat);
        checkCount++;
        if (e !== 1'b1) $display("[TB] FAIL oor_top_addr_err: got %b expected 1", e);
        else passCount++;
        doTxn(1, 1'b0, 10'h000, 8'h00, rd, e, lat);
        checkCount++;
        if (e !== 1'b0 || rd !== 8'h42)
            $display("[TB] FAIL oor_no_corrupt: got err=%b data=%h expected err=0 data=42", e, rd);
        else passCount++;
        doTxn(1, 1'b0, 10'h1FF, 8'h00, rd, e, lat);
        checkCount++;
        if (e !== 1'b0) $display("[TB] FAIL oor_last_valid_err: got %b expected 0", e);
        else passCount++;
    endtask

    task automatic test_backpressure();
        logic [7:0] rd;
        logic       e;
        int         lat;
        applyReset();
        respReady = 1'b0;
        doTxn(0, 1'b0, 10'h003, 8'h00, rd, e, lat);
        for (int i = 0; i < 5; i++) begin
            checkCount++;
            if (dataOut[0] !== 8'hA5 || reqReady[0] !== 1'b0 || respValid[0] !== 1'b1)
                $display("[TB] FAIL bp_hold_%0d: got data=%h ready=%b valid=%b expected data=a5 ready=0 valid=1",
                         i, dataOut[0], reqReady[0], respValid[0]);
            else passCount++;
            if (i == 1) begin
                reqValid = 1'b1;
                reqWren  = 1'b1;
                reqAddr  = 10'h003;
                reqData  = 8'hFF;
            end else if (i == 2) begin
                reqValid = 1'b0;
            end
            @(posedge clk); #1;
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (respValid[0] !== 1'b0 || busy[0] !== 1'b0)
            $display("[TB] FAIL bp_complete: got valid=%b busy=%b expected valid=0 busy=0", respValid[0], busy[0]);
        else passCount++;
        checkCount++;
        if (dataOut[0] !== 8'hA5) $display("[TB] FAIL bp_data_held: got %h expected a5", dataOut[0]);
        else passCount++;
        doTxn(0, 1'b0, 10'h003, 8'h00, rd, e, lat);
        checkCount++;
        if (rd !== 8'hA5) $display("[TB] FAIL bp_pulse_ignored: got %h expected a5", rd);
        else passCount++;
    endtask

    task automatic test_reset_abort();
        logic [7:0] rd;
        logic       e;
        int         lat;
        applyReset();
        doTxn(2, 1'b1, 10'h010, 8'h77, rd, e, lat);
        checkCount++;
        if (lat !== 6) $display("[TB] FAIL ws4_latency: got %0d expected 6", lat);
        else passCount++;
        reqValid = 1'b1;
        reqWren  = 1'b1;
        reqAddr  = 10'h010;
        reqData  = 8'h11;
        @(posedge clk); #1;
        reqValid = 1'b0;
        checkCount++;
        if (busy[2] !== 1'b1) $display("[TB] FAIL abort_in_wait: got busy=%b expected 1", busy[2]);
        else passCount++;
        @(posedge clk); #1;
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        checkCount++;
        if (busy[2] !== 1'b0 || reqReady[2] !== 1'b1 || respValid[2] !== 1'b0)
            $display("[TB] FAIL abort_idle: got busy=%b ready=%b valid=%b expected 0 1 0",
                     busy[2], reqReady[2], respValid[2]);
        else passCount++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkCount++;
            if (respValid[2] !== 1'b0) $display("[TB] FAIL abort_no_resp_%0d: got %b expected 0", i, respValid[2]);
            else passCount++;
        end
        doTxn(2, 1'b0, 10'h010, 8'h00, rd, e, lat);
        checkCount++;
        if (rd !== 8'h77) $display("[TB] FAIL abort_not_committed: got %h expected 77", rd);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic       e;
        int         lat;
        logic [7:0] expv;
        applyReset();
        for (int i = 0; i < 8; i++) begin
            expv = 8'(i) ^ 8'h5A;
            doTxn(3, 1'b1, 10'(i), expv, rd, e, lat);
            checkCount++;
            if (lat !== 2 || rd !== expv)
                $display("[TB] FAIL b2b_wr_%0d: got lat=%0d data=%h expected lat=2 data=%h", i, lat, rd, expv);
            else passCount++;
        end
        for (int i = 0; i < 8; i++) begin
            expv = 8'(i) ^ 8'h5A;
            doTxn(3, 1'b0, 10'(i), 8'h00, rd, e, lat);
            checkCount++;
            if (lat !== 2 || rd !== expv || e !== 1'b0)
                $display("[TB] FAIL b2b_rd_%0d: got lat=%0d data=%h err=%b expected lat=2 data=%h err=0",
                         i, lat, rd, e, expv);
            else passCount++;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        resetN     = 1'b0;
        reqValid   = 1'b0;
        reqAddr    = '0;
        reqWren    = 1'b0;
        reqData    = '0;
        respReady  = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
